// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes the async reset release, stretches it, then
// releases N_OUT domain resets one after another, GAP_CYCLES apart.
module rst_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int N_OUT          = 3,
    parameter int GAP_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             asyncrst_n,
    input  logic             sw_rst_req,
    output logic [N_OUT-1:0] rst_n,
    output logic             ready,
    output logic             rst_cause_sw
);

    // state     | meaning
    // S_HOLD    | held by sync_n; its first clock is already the first stretch cycle
    // S_STRETCH | all outputs held, counting down the stretch interval
    // S_RELEASE | some outputs released, counting down the gap to the next one
    // S_RUN     | all outputs released, ready high
    typedef enum logic [1:0] {
        S_HOLD,
        S_STRETCH,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam int MAX_CNT = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] STRETCH_LD    = CW'(STRETCH_CYCLES);
    localparam logic [CW-1:0] STRETCH_LD_M1 = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD        = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("rst_sequencer: SYNC_STAGES must be >= 2");
    end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch
        $error("rst_sequencer: STRETCH_CYCLES must be >= 1");
    end
    if (N_OUT < 1) begin : g_bad_nout
        $error("rst_sequencer: N_OUT must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("rst_sequencer: GAP_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_OUT-1:0]  rst_n_q, rst_n_d;
    logic              ready_q, ready_d;
    logic              cause_q, cause_d;
    logic              release_now;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_n_d     = rst_n_q;
        ready_d     = ready_q;
        cause_d     = cause_q;
        release_now = 1'b0;

        // The FSM only sees clock edges once sync_n is high, so a software
        // request is honoured in every state it can observe.
        if (sw_rst_req) begin
            state_d = S_STRETCH;
            cnt_d   = STRETCH_LD;
            rst_n_d = '0;
            ready_d = 1'b0;
            cause_d = 1'b1;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (STRETCH_CYCLES == 1) begin
                        release_now = 1'b1;
                    end else begin
                        state_d = S_STRETCH;
                        cnt_d   = STRETCH_LD_M1;
                    end
                end
                S_STRETCH, S_RELEASE: begin
                    if (cnt_q == CNT_ONE) begin
                        release_now = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase

            if (release_now) begin
                rst_n_d = N_OUT'({rst_n_q, 1'b1});
                if (&rst_n_d) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = S_RELEASE;
                    cnt_d   = GAP_LD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sync_n) begin
        if (!sync_n) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign rst_n        = rst_n_q;
    assign ready        = ready_q;
    assign rst_cause_sw = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance plus a minimal-parameter instance,
// checked every cycle against a release-edge arithmetic model.
module tb_rst_sequencer;

    localparam int NDUT = 2;
    localparam int P_SS [NDUT] = '{2, 3};
    localparam int P_ST [NDUT] = '{16, 1};
    localparam int P_N  [NDUT] = '{3, 1};
    localparam int P_GP [NDUT] = '{4, 1};

    logic       clk        = 1'b0;
    logic       asyncrst_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [2:0] rst_n_a;
    logic       ready_a;
    logic       cause_a;
    logic [0:0] rst_n_b;
    logic       ready_b;
    logic       cause_b;

    int edge_n   = 0;
    int checks   = 0;
    int failures = 0;

    // Model: a sequence that started at edge e releases bit k at e+ST+k*GAP.
    bit need_arm = 1'b1;
    bit armed   [NDUT];
    int e_edge  [NDUT];
    bit m_cause [NDUT];

    rst_sequencer dut_a (
        .clk          (clk),
        .asyncrst_n   (asyncrst_n),
        .sw_rst_req   (sw_rst_req),
        .rst_n        (rst_n_a),
        .ready        (ready_a),
        .rst_cause_sw (cause_a)
    );

    rst_sequencer #(
        .SYNC_STAGES    (3),
        .STRETCH_CYCLES (1),
        .N_OUT          (1),
        .GAP_CYCLES     (1)
    ) dut_b (
        .clk          (clk),
        .asyncrst_n   (asyncrst_n),
        .sw_rst_req   (sw_rst_req),
        .rst_n        (rst_n_b),
        .ready        (ready_b),
        .rst_cause_sw (cause_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%b expected=%b", name, edge_n, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_rst(input int i);
        logic [2:0] v;
        v = '0;
        for (int k = 0; k < P_N[i]; k++) begin
            if (armed[i] && edge_n >= e_edge[i] + P_ST[i] + k * P_GP[i]) v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [2:0] full_mask(input int i);
        return 3'((1 << P_N[i]) - 1);
    endfunction

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            armed[i]   = 1'b0;
            e_edge[i]  = 0;
            m_cause[i] = 1'b0;
        end
    end

    initial forever begin
        @(negedge asyncrst_n);
        need_arm = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            armed[i]   = 1'b0;
            m_cause[i] = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        edge_n++;
        if (asyncrst_n) begin
            if (need_arm) begin
                need_arm = 1'b0;
                for (int i = 0; i < NDUT; i++) begin
                    armed[i]  = 1'b1;
                    e_edge[i] = edge_n + P_SS[i] - 1;
                end
            end else begin
                for (int i = 0; i < NDUT; i++) begin
                    if (armed[i] && sw_rst_req && edge_n > e_edge[i]) begin
                        e_edge[i]  = edge_n;
                        m_cause[i] = 1'b1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            chk("a.rst_n", rst_n_a, exp_rst(0));
            chk("a.ready", {2'b0, ready_a}, {2'b0, exp_rst(0) == full_mask(0)});
            chk("a.cause", {2'b0, cause_a}, {2'b0, m_cause[0]});
            chk("b.rst_n", {2'b0, rst_n_b}, exp_rst(1));
            chk("b.ready", {2'b0, ready_b}, {2'b0, exp_rst(1) == full_mask(1)});
            chk("b.cause", {2'b0, cause_b}, {2'b0, m_cause[1]});
        end
    end

    task automatic to_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic async_pulse(input string tag);
        #1 asyncrst_n = 1'b0;
        #1;
        chk({tag, ".a_rst_n"}, rst_n_a, 3'b000);
        chk({tag, ".a_ready"}, {2'b0, ready_a}, 3'b000);
        chk({tag, ".a_cause"}, {2'b0, cause_a}, 3'b000);
        chk({tag, ".b_rst_n"}, {2'b0, rst_n_b}, 3'b000);
        #1 asyncrst_n = 1'b1;
    endtask

    initial begin
        int end_edge;
        #1 asyncrst_n = 1'b0;
        #1;
        chk("por.a_rst_n", rst_n_a, 3'b000);
        chk("por.a_ready", {2'b0, ready_a}, 3'b000);
        chk("por.a_cause", {2'b0, cause_a}, 3'b000);
        #1 asyncrst_n = 1'b1;

        to_edge(3);  chk("sweep.e3_rst", {2'b0, rst_n_b}, 3'b000);
        to_edge(4);  chk("sweep.e4_rst", {2'b0, rst_n_b}, 3'b001);
                     chk("sweep.e4_rdy", {2'b0, ready_b}, 3'b001);
        to_edge(17); chk("por.e17", rst_n_a, 3'b000);
        to_edge(18); chk("por.e18", rst_n_a, 3'b001);
        to_edge(22); chk("por.e22", rst_n_a, 3'b011);
        to_edge(26); chk("por.e26", rst_n_a, 3'b111);
                     chk("por.e26_rdy", {2'b0, ready_a}, 3'b001);
                     chk("por.e26_cause", {2'b0, cause_a}, 3'b000);

        to_edge(99);  sw_rst_req = 1'b1;
        to_edge(100); sw_rst_req = 1'b0;
        chk("sw.e100_rst", rst_n_a, 3'b000);
        chk("sw.e100_rdy", {2'b0, ready_a}, 3'b000);
        chk("sw.e100_cause", {2'b0, cause_a}, 3'b001);
        to_edge(115); chk("sw.e115", rst_n_a, 3'b000);
        to_edge(116); chk("sw.e116", rst_n_a, 3'b001);
        to_edge(120); chk("sw.e120", rst_n_a, 3'b011);
        to_edge(124); chk("sw.e124", rst_n_a, 3'b111);

        // Fresh power-on at edge 131, then pulse between its edges 20 and 21.
        to_edge(130); async_pulse("repor");
        to_edge(150); chk("mid.before", rst_n_a, 3'b001);
        async_pulse("mid");
        to_edge(167); chk("mid.e167", rst_n_a, 3'b000);
        to_edge(168); chk("mid.e168", rst_n_a, 3'b001);
        to_edge(176); chk("mid.e176", rst_n_a, 3'b111);

        to_edge(180);
        sw_rst_req = 1'b1;
        #1 asyncrst_n = 1'b0;
        to_edge(181);
        sw_rst_req = 1'b0;
        chk("both.cause", {2'b0, cause_a}, 3'b000);
        chk("both.rst_n", rst_n_a, 3'b000);
        #1 asyncrst_n = 1'b1;
        to_edge(206); chk("both.e206_rdy", {2'b0, ready_a}, 3'b000);
        to_edge(207); chk("both.e207_rdy", {2'b0, ready_a}, 3'b001);

        to_edge(220); sw_rst_req = 1'b1;
        to_edge(260); sw_rst_req = 1'b0;
        to_edge(275); chk("hold.e275", rst_n_a, 3'b000);
        to_edge(276); chk("hold.e276", rst_n_a, 3'b001);
                      chk("hold.cause", {2'b0, cause_a}, 3'b001);

        to_edge(300);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            sw_rst_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) async_pulse("rnd");
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        end_edge = edge_n + 40;
        to_edge(end_edge);
        chk("final.a_rdy", {2'b0, ready_a}, 3'b001);
        chk("final.b_rdy", {2'b0, ready_b}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in the reset-release synchronizer chain (legal ≥2).
REQ-002 SHALL have parameter STRETCH_CYCLES, default 16: number of cycles all outputs stay held after the synchronized release (legal ≥1).
REQ-003 SHALL have parameter N_OUT, default 3: number of sequenced reset outputs (legal ≥1).
REQ-004 SHALL have parameter GAP_CYCLES, default 4: number of cycles between successive output releases (legal ≥1).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port asyncrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port sw_rst_req, input, 1 bit: synchronous software reset request, sampled on clk.
REQ-008 SHALL have port rst_n, output, N_OUT bits: active-low domain resets; bit 0 releases first.
REQ-009 SHALL have port ready, output, 1 bit: high when all rst_n bits are released.
REQ-010 SHALL have port rst_cause_sw, output, 1 bit: 1 if the most recent reset came from sw_rst_req, 0 if it came from asyncrst_n.

Function
REQ-011 SHALL contain a SYNC_STAGES-deep synchronizer chain:
- cleared asynchronously by asyncrst_n low;
- shifts in 1 otherwise;
- its last stage (sync_n) is the internal reset for all other flops (asynchronous assert, synchronous release).
REQ-012 SHALL implement the FSM HOLD -> STRETCH -> RELEASE -> RUN:
- HOLD while sync_n=0;
- STRETCH at the first edge where sync_n=1, called edge E.
REQ-013 SHALL count STRETCH_CYCLES cycles in STRETCH, then drive rst_n[0] high at edge E+STRETCH_CYCLES and enter RELEASE.
REQ-014 SHALL drive rst_n[k] high at edge E+STRETCH_CYCLES+k*GAP_CYCLES, for k=1..N_OUT-1; once released, a bit stays high until the next reset.
REQ-015 SHALL enter RUN and drive ready high on the same edge that releases rst_n[N_OUT-1]; for N_OUT=1, this edge is E+STRETCH_CYCLES.
REQ-016 SHALL act on sw_rst_req sampled high at edge S in STRETCH, RELEASE or RUN:
- drive all rst_n bits and ready low after edge S;
- set rst_cause_sw=1;
- restart STRETCH with S taking the place of E.
REQ-017 SHALL ignore sw_rst_req while in HOLD.
REQ-018 SHALL treat sw_rst_req held high continuously as repeated restarts, so no rst_n bit releases while it stays high.
REQ-019 SHALL drive all rst_n bits and ready low, and set rst_cause_sw=0, immediately and without a clock whenever asyncrst_n falls, in any state, including mid-STRETCH and mid-RELEASE.
REQ-020 SHALL give asyncrst_n priority over sw_rst_req when both are active in the same cycle.
REQ-021 SHALL make the release counter wide enough for max(STRETCH_CYCLES, GAP_CYCLES) with no wrap-around, and reload it at each state entry and each output release.
REQ-022 SHALL drive every output directly from a flop, with no combinational path from any input to any output except the asynchronous clear.
REQ-023 SHALL check the legal parameter ranges at elaboration and fail elaboration when any is violated.

Reset
REQ-024 SHALL hold these values while asyncrst_n=0: rst_n='0, ready=0, rst_cause_sw=0, FSM=HOLD, counter=0, synchronizer chain all 0.
REQ-025 SHALL keep the outputs at their reset values after asyncrst_n rises, until the FSM leaves HOLD by REQ-011/REQ-012.

Verification
REQ-026 SHALL cover power-on with defaults: asyncrst_n rises before edge 1 -> E=2; rst_n becomes 001 at edge 18, 011 at edge 22, 111 at edge 26; ready=1 at edge 26; rst_cause_sw=0.
REQ-027 SHALL cover a software reset: sw_rst_req high for one cycle, sampled at edge 100 in RUN -> rst_n=000, ready=0 and rst_cause_sw=1 after edge 100; rst_n[0] rises at edge 116, rst_n[1] at 120, rst_n[2] at 124.
REQ-028 SHALL cover an asynchronous reset mid-release: asyncrst_n pulsed low between edges 20 and 21 of power-on -> rst_n=000 with no clock edge needed; the full sequence restarts from HOLD with E two edges after the rise.
REQ-029 SHALL cover simultaneous events: asyncrst_n low and sw_rst_req high in the same cycle -> rst_cause_sw=0 and the FSM is in HOLD.
REQ-030 SHALL cover sw_rst_req held high for 40 cycles in RUN -> rst_n stays 000 throughout; rst_n[0] releases 16 edges after the last edge that samples sw_rst_req high.
REQ-031 SHALL cover a parameter sweep with SYNC_STAGES=3, STRETCH_CYCLES=1, N_OUT=1, GAP_CYCLES=1 -> E=3; rst_n[0]=1 and ready=1 at edge 4.
